mrd_rdx2345_wrback: RTL and testbench
=====================================

# mrd_rdx2345_wrback

Write-back stage directly downstream of the radix-2/3/4/5 + twiddle stage in the mixed-radix DFT engine. Accepts one 5-lane butterfly result per valid beat (data, bank index, bank address, block exponent), routes each lane through a 5x5 crossbar to its target RAM bank, and issues per-bank write enables. Counts beats against the stage length and pulses `stage_done` when the stage's last write is issued. Flags bank conflicts and unexpected beats for the sequencer.

## Interface
- `wData`, 18, lane data width (real and imag each, signed)
- `wAddr`, 8, bank address width
- `wLen`, 10, stage-length counter width
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `sop` in 1: start of stage; samples `stage_len`
- `stage_len` in wLen: butterfly beats in this stage, 0..1023
- `in_valid` in 1: beat valid
- `in_real[0:4]`, `in_imag[0:4]` in 5 x wData: lane data
- `in_bank_index[0:4]` in 5 x 3: target bank per lane; legal values 0..4
- `in_bank_addr[0:4]` in 5 x wAddr: address within the target bank
- `in_exp` in 4: block exponent accompanying the beat
- `wren[0:4]` out 5 x 1: per-bank write enable
- `wraddr[0:4]` out 5 x wAddr; `wrdata_real[0:4]`, `wrdata_imag[0:4]` out 5 x wData
- `stage_done` out 1: one-cycle pulse
- `exp_stage` out 4: exponent latched from first beat of stage
- `beat_cnt` out wLen: accepted beats in current stage
- `err_conflict` out 1: sticky; two lanes hit the same bank in one beat
- `err_index` out 1: sticky; lane bank index 5..7
- `err_unexp` out 1: sticky; valid beat outside RUN

## Operation
- FSM states IDLE, RUN, DONE. Reset -> IDLE.
- `sop` from any state: clear `beat_cnt`, clear the three error flags, load `stage_len`; `stage_len`=0 -> DONE with `stage_done` pulse next cycle; otherwise -> RUN.
- RUN: each `in_valid` beat is accepted, `beat_cnt`++; beat whose count reaches `stage_len` moves FSM to DONE.
- First accepted beat of a stage latches `in_exp` into `exp_stage`; later beats do not change it.
- `in_valid` with `sop` in the same cycle: beat belongs to the new stage and is beat 1.
- `in_valid` in IDLE or DONE (without `sop`): beat discarded, no write, `err_unexp` set.
- Crossbar: for bank b, select lane i with `in_bank_index[i]==b`; `wren[b]`=1 with that lane's address/data. No matching lane -> `wren[b]`=0.
- Multiple lanes to bank b: lowest-numbered lane wins, others dropped, `err_conflict` set.
- Lane index 5..7: lane dropped, `err_index` set.
- Data passes unmodified; no rounding or saturation.

## Timing
- Pipeline: stage 1 registers inputs; stage 2 registers crossbar outputs. Beat sampled at edge t -> `wren`/`wraddr`/`wrdata` valid in cycle t+2, held one cycle.
- Full throughput: one beat per cycle, no back-pressure.
- `stage_done` asserted in the same cycle as the last beat's `wren` (t+2 of final beat); one cycle wide. For `stage_len`=0, pulse in cycle after `sop`.
- `beat_cnt`, FSM, `exp_stage` update at edge t (same edge beat is sampled). Error flags set aligned with the beat's `wren` cycle (t+2).
- `sop` while beats are in the pipeline: in-flight writes still complete; `stage_done` for the old stage is suppressed if not yet issued.
- Reset values: all `wren`=0, `wraddr`/`wrdata`=0, `stage_done`=0, `exp_stage`=0, `beat_cnt`=0, all error flags 0. `rst` mid-stage discards in-flight beats: no write issued after the reset edge.
- `beat_cnt` saturates at `stage_len`; no wrap.

## Test plan
- Reset then `sop`, `stage_len`=3, three beats with bank_index {0,1,2,3,4}, addr=beat# -> each bank written at t+2 with addr 0,1,2; `stage_done` coincident with third write; `beat_cnt`=3; all errors 0.
- Permuted lanes `in_bank_index`={4,3,2,1,0}, `in_real[i]`=100+i -> `wrdata_real[4]`=100, `wrdata_real[0]`=104.
- Lanes 1 and 3 both index 2, lane 4 index 7 -> bank 2 gets lane 1 data, `wren[3..4]` per remaining lanes, `err_conflict`=1, `err_index`=1, both held until next `sop`.
- `stage_len`=2, four back-to-back beats -> two writes, `stage_done` once, beats 3-4 dropped, `err_unexp`=1; `exp_stage` equals beat 1 `in_exp`=5 though later beats carry 7.
- `sop` coincident with valid beat while previous stage's last beat is in flight -> old beat written, no old `stage_done`, new `beat_cnt`=1.
- Assert `rst` one cycle after a beat -> no `wren` at t+2; all outputs 0; next `sop` operates normally.

Source files
------------

// File: rtl/mrd_rdx2345_wrback_if.sv
// mrd_rdx2345_wrback_if: butterfly beat input and per-bank write bus of the write-back stage
interface mrd_rdx2345_wrback_if #(
   parameter int wData = 18,
   parameter int wAddr = 8
);
   logic                    in_valid;
   logic signed [wData-1:0] in_real       [0:4];
   logic signed [wData-1:0] in_imag       [0:4];
   logic [2:0]              in_bank_index [0:4];
   logic [wAddr-1:0]        in_bank_addr  [0:4];
   logic [3:0]              in_exp;
   logic                    wren          [0:4];
   logic [wAddr-1:0]        wraddr        [0:4];
   logic signed [wData-1:0] wrdata_real   [0:4];
   logic signed [wData-1:0] wrdata_imag   [0:4];
   modport master (
      output in_valid, in_real, in_imag, in_bank_index, in_bank_addr, in_exp,
      input  wren, wraddr, wrdata_real, wrdata_imag
   );
   modport slave (
      input  in_valid, in_real, in_imag, in_bank_index, in_bank_addr, in_exp,
      output wren, wraddr, wrdata_real, wrdata_imag
   );
endinterface

// File: rtl/mrd_rdx2345_wrback.sv
// mrd_rdx2345_wrback: routes 5-lane butterfly results to RAM banks, counts stage beats, flags errors
module mrd_rdx2345_wrback #(
   parameter int wData = 18,
   parameter int wAddr = 8,
   parameter int wLen  = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sop,
   input  logic [wLen-1:0]      stage_len,
   mrd_rdx2345_wrback_if.slave  bus,
   output logic                 stage_done,
   output logic [3:0]           exp_stage,
   output logic [wLen-1:0]      beat_cnt,
   output logic                 err_conflict,
   output logic                 err_index,
   output logic                 err_unexp
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                  state, state_nx;
   logic [wLen-1:0]         len_q, len_eff, cnt_base, cnt_nx;
   logic                    accept, last;
   logic                    s1_valid, s1_last, s1_unexp;
   logic signed [wData-1:0] s1_real [0:4];
   logic signed [wData-1:0] s1_imag [0:4];
   logic [2:0]              s1_idx  [0:4];
   logic [wAddr-1:0]        s1_addr [0:4];
   logic [4:0]              hit, dup;
   logic [2:0]              sel [0:4];
   logic                    bad_index;
   // a beat arriving with sop is beat 1 of the new stage; the beat reaching stage_len ends it
   always_comb begin
      len_eff  = sop ? stage_len : len_q;
      cnt_base = sop ? '0 : beat_cnt;
      accept   = bus.in_valid && (sop ? stage_len != '0 : state == RUN);
      cnt_nx   = cnt_base + wLen'(accept);
      last     = accept && cnt_nx == len_eff;
      state_nx = state;
      if (sop)
         state_nx = (stage_len == '0 || last) ? DONE : RUN;
      else if (state == RUN && last)
         state_nx = DONE;
   end
   // FSM, beat counter, stage length and exponent update on the edge that samples the beat
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         beat_cnt  <= '0;
         exp_stage <= '0;
      end else begin
         state    <= state_nx;
         len_q    <= len_eff;
         beat_cnt <= cnt_nx;
         if (accept && cnt_base == '0)
            exp_stage <= bus.in_exp;
      end
   end
   // input pipeline register; rejected beats only carry their error marker forward
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_unexp <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_last  <= last;
         s1_unexp <= bus.in_valid && !accept;
      end
      s1_real <= bus.in_real;
      s1_imag <= bus.in_imag;
      s1_idx  <= bus.in_bank_index;
      s1_addr <= bus.in_bank_addr;
   end
   // crossbar select: scanning lanes high to low leaves the lowest matching lane selected
   always_comb begin
      hit       = '0;
      dup       = '0;
      bad_index = 1'b0;
      for (int b = 0; b < 5; b++) begin
         sel[b] = '0;
         for (int i = 4; i >= 0; i--) begin
            if (s1_idx[i] == 3'(b)) begin
               dup[b] = dup[b] | hit[b];
               hit[b] = 1'b1;
               sel[b] = 3'(i);
            end
         end
      end
      for (int i = 0; i < 5; i++)
         if (s1_idx[i] > 3'd4) bad_index = 1'b1;
   end
   // output register: bank writes, stage_done (suppressed by a new sop) and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 5; b++) begin
            bus.wren[b]        <= 1'b0;
            bus.wraddr[b]      <= '0;
            bus.wrdata_real[b] <= '0;
            bus.wrdata_imag[b] <= '0;
         end
         stage_done   <= 1'b0;
         err_conflict <= 1'b0;
         err_index    <= 1'b0;
         err_unexp    <= 1'b0;
      end else begin
         for (int b = 0; b < 5; b++) begin
            bus.wren[b]        <= s1_valid && hit[b];
            bus.wraddr[b]      <= (s1_valid && hit[b]) ? s1_addr[sel[b]] : '0;
            bus.wrdata_real[b] <= (s1_valid && hit[b]) ? s1_real[sel[b]] : '0;
            bus.wrdata_imag[b] <= (s1_valid && hit[b]) ? s1_imag[sel[b]] : '0;
         end
         stage_done   <= (sop && stage_len == '0) || (s1_valid && s1_last && !sop);
         err_conflict <= !sop && (err_conflict || (s1_valid && |dup));
         err_index    <= !sop && (err_index || (s1_valid && bad_index));
         err_unexp    <= !sop && (err_unexp || s1_unexp);
      end
   end
endmodule

// File: tb/tb_mrd_rdx2345_wrback.sv
// tb_mrd_rdx2345_wrback: directed checks of routing, stage counting, errors and reset
module tb_mrd_rdx2345_wrback;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sop = 1'b0;
   logic [9:0] stage_len = '0;
   logic       stage_done, err_conflict, err_index, err_unexp;
   logic [3:0] exp_stage;
   logic [9:0] beat_cnt;
   int         npass = 0;
   int         nfail = 0;
   int         ntot  = 0;

   mrd_rdx2345_wrback_if #(.wData(18), .wAddr(8)) bus ();

   mrd_rdx2345_wrback #(.wData(18), .wAddr(8), .wLen(10)) dut (
      .clk(clk), .rst(rst), .sop(sop), .stage_len(stage_len), .bus(bus),
      .stage_done(stage_done), .exp_stage(exp_stage), .beat_cnt(beat_cnt),
      .err_conflict(err_conflict), .err_index(err_index), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntot++;
      assert (obs === expv) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] wv();
      return {27'b0, bus.wren[4], bus.wren[3], bus.wren[2], bus.wren[1], bus.wren[0]};
   endfunction

   task automatic beat(input bit v, input logic [2:0] i0, i1, i2, i3, i4,
                       input int a, input int r, input logic [3:0] e);
      logic [2:0] ix [0:4];
      ix = '{i0, i1, i2, i3, i4};
      bus.in_valid = v;
      bus.in_exp   = e;
      for (int i = 0; i < 5; i++) begin
         bus.in_bank_index[i] = ix[i];
         bus.in_bank_addr[i]  = 8'(a);
         bus.in_real[i]       = 18'(r + i);
         bus.in_imag[i]       = 18'(r + 100 + i);
      end
   endtask

   initial begin
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      tick();
      chk("rst_wren", wv(), 0);
      chk("rst_done", stage_done, 0);
      chk("rst_cnt", beat_cnt, 0);
      chk("rst_exp", exp_stage, 0);
      chk("rst_errs", {err_conflict, err_index, err_unexp}, 0);
      chk("rst_addr", bus.wraddr[0], 0);
      rst = 1'b0;
      // three-beat stage, identity routing
      sop = 1'b1; stage_len = 10'd3;
      beat(1, 0, 1, 2, 3, 4, 0, 10, 3);
      tick();
      chk("t1_cnt1", beat_cnt, 1);
      chk("t1_exp", exp_stage, 3);
      chk("t1_nowr", wv(), 0);
      sop = 1'b0;
      beat(1, 0, 1, 2, 3, 4, 1, 20, 9);
      tick();
      chk("t1_wren1", wv(), 5'h1f);
      chk("t1_addr1", bus.wraddr[0], 0);
      chk("t1_re2", bus.wrdata_real[2], 12);
      chk("t1_im4", bus.wrdata_imag[4], 114);
      chk("t1_cnt2", beat_cnt, 2);
      chk("t1_done1", stage_done, 0);
      chk("t1_exp2", exp_stage, 3);
      beat(1, 0, 1, 2, 3, 4, 2, 30, 9);
      tick();
      chk("t1_addr2", bus.wraddr[3], 1);
      chk("t1_re1", bus.wrdata_real[1], 21);
      chk("t1_cnt3", beat_cnt, 3);
      chk("t1_done2", stage_done, 0);
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      chk("t1_wren3", wv(), 5'h1f);
      chk("t1_addr3", bus.wraddr[4], 2);
      chk("t1_re0", bus.wrdata_real[0], 30);
      chk("t1_done3", stage_done, 1);
      chk("t1_errs", {err_conflict, err_index, err_unexp}, 0);
      chk("t1_cntsat", beat_cnt, 3);
      tick();
      chk("t1_donepulse", stage_done, 0);
      chk("t1_wrend", wv(), 0);
      // reversed lane permutation
      sop = 1'b1; stage_len = 10'd1;
      beat(1, 4, 3, 2, 1, 0, 7, 100, 1);
      tick();
      sop = 1'b0;
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      chk("t2_re4", bus.wrdata_real[4], 100);
      chk("t2_re0", bus.wrdata_real[0], 104);
      chk("t2_im1", bus.wrdata_imag[1], 203);
      chk("t2_addr", bus.wraddr[2], 7);
      chk("t2_done", stage_done, 1);
      // conflict on bank 2 and illegal index on lane 4
      sop = 1'b1; stage_len = 10'd1;
      beat(1, 0, 2, 3, 2, 7, 9, 50, 2);
      tick();
      sop = 1'b0;
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      chk("t3_wren", wv(), 5'b01101);
      chk("t3_re2", bus.wrdata_real[2], 51);
      chk("t3_re3", bus.wrdata_real[3], 52);
      chk("t3_re0", bus.wrdata_real[0], 50);
      chk("t3_conf", err_conflict, 1);
      chk("t3_idx", err_index, 1);
      chk("t3_unexp", err_unexp, 0);
      tick();
      tick();
      chk("t3_confhold", err_conflict, 1);
      chk("t3_idxhold", err_index, 1);
      // stage_len=2 with four back-to-back beats
      sop = 1'b1; stage_len = 10'd2;
      beat(1, 0, 1, 2, 3, 4, 0, 60, 5);
      tick();
      chk("t4_confclr", err_conflict, 0);
      chk("t4_idxclr", err_index, 0);
      chk("t4_exp", exp_stage, 5);
      chk("t4_cnt1", beat_cnt, 1);
      sop = 1'b0;
      beat(1, 0, 1, 2, 3, 4, 1, 70, 7);
      tick();
      chk("t4_wren1", wv(), 5'h1f);
      chk("t4_done1", stage_done, 0);
      chk("t4_cnt2", beat_cnt, 2);
      beat(1, 0, 1, 2, 3, 4, 2, 80, 7);
      tick();
      chk("t4_done2", stage_done, 1);
      chk("t4_re0", bus.wrdata_real[0], 70);
      beat(1, 0, 1, 2, 3, 4, 3, 90, 7);
      tick();
      chk("t4_drop", wv(), 0);
      chk("t4_done3", stage_done, 0);
      chk("t4_unexp", err_unexp, 1);
      chk("t4_cntsat", beat_cnt, 2);
      chk("t4_exphold", exp_stage, 5);
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      chk("t4_drop2", wv(), 0);
      chk("t4_unexphold", err_unexp, 1);
      tick();
      // sop with a beat while the previous stage's last beat is in flight
      sop = 1'b1; stage_len = 10'd1;
      beat(1, 0, 1, 2, 3, 4, 4, 300, 4);
      tick();
      sop = 1'b1; stage_len = 10'd2;
      beat(1, 0, 1, 2, 3, 4, 5, 400, 6);
      tick();
      chk("t5_cnt", beat_cnt, 1);
      chk("t5_oldwr", wv(), 5'h1f);
      chk("t5_oldre", bus.wrdata_real[0], 300);
      chk("t5_nodone", stage_done, 0);
      chk("t5_exp", exp_stage, 6);
      sop = 1'b0;
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      chk("t5_newre", bus.wrdata_real[0], 400);
      chk("t5_newaddr", bus.wraddr[0], 5);
      chk("t5_nodone2", stage_done, 0);
      // zero-length stage
      sop = 1'b1; stage_len = 10'd0;
      tick();
      chk("t0_done", stage_done, 1);
      chk("t0_cnt", beat_cnt, 0);
      sop = 1'b0;
      tick();
      chk("t0_pulse", stage_done, 0);
      // reset one cycle after a beat
      sop = 1'b1; stage_len = 10'd4;
      beat(1, 0, 1, 2, 3, 4, 6, 600, 3);
      tick();
      sop = 1'b0;
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      rst = 1'b1;
      tick();
      chk("t6_nowr", wv(), 0);
      chk("t6_cnt", beat_cnt, 0);
      chk("t6_exp", exp_stage, 0);
      chk("t6_addr", bus.wraddr[0], 0);
      rst = 1'b0;
      tick();
      chk("t6_nowr2", wv(), 0);
      sop = 1'b1; stage_len = 10'd1;
      beat(1, 0, 1, 2, 3, 4, 8, 500, 2);
      tick();
      sop = 1'b0;
      beat(0, 0, 1, 2, 3, 4, 0, 0, 0);
      tick();
      chk("t6_wren", wv(), 5'h1f);
      chk("t6_re0", bus.wrdata_real[0], 500);
      chk("t6_addr1", bus.wraddr[1], 8);
      chk("t6_done", stage_done, 1);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
